// File: rtl/rr_child_scheduler_if.sv
// ---------------------------------------------------------------------------
// rr_child_scheduler_if
// Bundle between a hierarchy node's children and its round-robin scheduler.
//
// Parameters:
//   N_REQ  number of requesting children (2..16)
//   ID_W   derived width of gnt_id, $clog2(N_REQ)
//
// Signals:
//   req      children -> scheduler  per-child request level
//   done_in  owner    -> scheduler  current owner finished (qualified by busy)
//   gnt      scheduler -> children  one-hot grant
//   gnt_id   scheduler -> children  binary index of the current owner
//   busy     scheduler -> children  resource owned (gnt != 0)
//   timeout  scheduler -> children  one-cycle pulse on forced release
//
// Modports:
//   master  scheduler side (drives the grant signals)
//   slave   child/resource side (drives req and done_in)
// ---------------------------------------------------------------------------
interface rr_child_scheduler_if #(
    parameter int N_REQ = 5
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic             done_in;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        input  req,
        input  done_in,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done_in,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );
endinterface : rr_child_scheduler_if

// File: rtl/rr_child_scheduler.sv
// ---------------------------------------------------------------------------
// rr_child_scheduler
// Round-robin owner selection for one shared resource among N_REQ children.
// A grant is held until the owner signals done_in or withdraws its request;
// other requests never preempt. Search for the next owner starts one past
// the previous owner, so after reset child 0 has top priority.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   rr_child_scheduler_if.master (req, done_in in; gnt, gnt_id,
//         busy, timeout out -- all outputs registered)
//
// Optional build macro:
//   RR_SCHED_TIMEOUT_EN  forces release after MAX_HOLD grant cycles and
//                        pulses timeout; without it timeout is tied low and
//                        MAX_HOLD has no effect.
// ---------------------------------------------------------------------------
module rr_child_scheduler #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_child_scheduler_if.master bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  last_q, last_d;

    logic             sel_found_s;
    logic [ID_W-1:0]  sel_s;
    logic [ID_W:0]    idx_s;
    logic             release_s;
    logic             forced_s;

    // Rotating priority search: first request at last+1, last+2, ... with wrap.
    // The extra index bit holds last+i before the wrap subtraction.
    always_comb begin
        sel_found_s = 1'b0;
        sel_s       = {ID_W{1'b0}};
        idx_s       = {(ID_W+1){1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = {1'b0, last_q} + (ID_W+1)'(i);
            if (idx_s >= (ID_W+1)'(N_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!sel_found_s && bus.req[idx_s[ID_W-1:0]]) begin
                sel_found_s = 1'b1;
                sel_s       = idx_s[ID_W-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Withdrawal of the owner's request is treated exactly like done_in.
    assign release_s = bus.done_in || !bus.req[gnt_id_q];

`ifdef RR_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    // A normal release on the same edge takes precedence over the forced one.
    assign forced_s = (state_q == ST_GRANT) &&
                      (hold_q == HOLD_W'(MAX_HOLD - 1)) && !release_s;

    // Hold counter restarts at zero on every grant edge and counts grant cycles.
    always_comb begin
        hold_d    = {HOLD_W{1'b0}};
        timeout_d = forced_s;
        if (state_q == ST_GRANT) begin
            hold_d = hold_q + HOLD_W'(1);
        end else begin
            hold_d = {HOLD_W{1'b0}};
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= {HOLD_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // MAX_HOLD only matters in the timeout build.
    logic unused_max_hold_s;
    assign unused_max_hold_s = (MAX_HOLD >= 2);
    assign forced_s          = 1'b0;
    assign bus.timeout       = 1'b0;
`endif

    // Next-state and output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << sel_s;
                    gnt_id_d = sel_s;
                    busy_d   = 1'b1;
                    state_d  = ST_GRANT;
                end else begin
                    gnt_d  = {N_REQ{1'b0}};
                    busy_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s || forced_s) begin
                    gnt_d   = {N_REQ{1'b0}};
                    busy_d  = 1'b0;
                    last_d  = gnt_id_q;
                    state_d = ST_IDLE;
                end else begin
                    gnt_d = gnt_q;
                end
            end
            default: begin
                gnt_d   = {N_REQ{1'b0}};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and priority-pointer registers; reset makes child 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= {N_REQ{1'b0}};
            gnt_id_q <= {ID_W{1'b0}};
            busy_q   <= 1'b0;
            last_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;
endmodule : rr_child_scheduler

// File: tb/tb_rr_child_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_child_scheduler
// Directed bench for rr_child_scheduler with N_REQ=5, MAX_HOLD=16.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so each tick() covers exactly one scheduler decision.
// ---------------------------------------------------------------------------
module tb_rr_child_scheduler;
    localparam int N_REQ    = 5;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    rr_child_scheduler_if #(.N_REQ(N_REQ)) bus ();

    rr_child_scheduler #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] e_gnt,
                           input logic [2:0] e_id, input logic e_busy, input logic e_to);
        chk({tag, ".gnt"},     32'(bus.gnt),     32'(e_gnt));
        chk({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(e_id));
        chk({tag, ".busy"},    32'(bus.busy),    32'(e_busy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(e_to));
    endtask

    initial begin
        logic [4:0] oh;
        pass_cnt    = 0;
        fail_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        bus.req     = 5'b00000;
        bus.done_in = 1'b0;
        tick();
        tick();
        chk_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester: 1-cycle latency, held until done_in.
        bus.req = 5'b00100;
        tick();
        chk_out("single.grant", 5'b00100, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("single.hold", 5'b00100, 3'd2, 1'b1, 1'b0);
        bus.done_in = 1'b1;
        tick();
        chk_out("single.release", 5'b00000, 3'd2, 1'b0, 1'b0);
        bus.done_in = 1'b0;
        bus.req     = 5'b00000;
        tick();
        chk_out("single.idle", 5'b00000, 3'd2, 1'b0, 1'b0);

        // Re-reset so the pointer restarts at child 0 for the rotation run.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Rotation with all children requesting: 0,1,2,3,4,0 with one idle cycle each.
        bus.req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            oh = 5'b00001 << (k % 5);
            tick();
            chk_out($sformatf("rot%0d.grant", k), oh, 3'(k % 5), 1'b1, 1'b0);
            bus.done_in = 1'b1;
            tick();
            bus.done_in = 1'b0;
            chk_out($sformatf("rot%0d.gap", k), 5'b00000, 3'(k % 5), 1'b0, 1'b0);
        end
        bus.req = 5'b00000;
        tick();

        // Pointer wrap: owner 3 released, then req 01001 must go to child 0.
        bus.req = 5'b01000;
        tick();
        chk_out("wrap.own3", 5'b01000, 3'd3, 1'b1, 1'b0);
        bus.done_in = 1'b1;
        bus.req     = 5'b01001;
        tick();
        bus.done_in = 1'b0;
        chk_out("wrap.gap", 5'b00000, 3'd3, 1'b0, 1'b0);
        tick();
        chk_out("wrap.own0", 5'b00001, 3'd0, 1'b1, 1'b0);

        // Other requests do not preempt the current owner.
        bus.req = 5'b01011;
        tick();
        chk_out("nopreempt", 5'b00001, 3'd0, 1'b1, 1'b0);

        // Withdrawal: release owner 0, grant owner 1, then owner 1 drops req.
        bus.done_in = 1'b1;
        bus.req     = 5'b00010;
        tick();
        bus.done_in = 1'b0;
        chk_out("wd.rel0", 5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        chk_out("wd.own1", 5'b00010, 3'd1, 1'b1, 1'b0);
        bus.req = 5'b00000;
        tick();
        chk_out("wd.dropped", 5'b00000, 3'd1, 1'b0, 1'b0);

        // done_in while idle is ignored.
        bus.done_in = 1'b1;
        tick();
        chk_out("idle.done", 5'b00000, 3'd1, 1'b0, 1'b0);
        bus.done_in = 1'b0;

        // Pointer is 1 after the withdrawal, so 00110 grants child 2.
        bus.req = 5'b00110;
        tick();
        chk_out("wd.ptr", 5'b00100, 3'd2, 1'b1, 1'b0);
        bus.done_in = 1'b1;
        bus.req     = 5'b00000;
        tick();
        bus.done_in = 1'b0;
        chk_out("wd.rel2", 5'b00000, 3'd2, 1'b0, 1'b0);

        // Long hold by child 4 (pointer 2 -> search 3,4,...).
        bus.req = 5'b10000;
        tick();
        chk_out("hold.grant", 5'b10000, 3'd4, 1'b1, 1'b0);
`ifdef RR_SCHED_TIMEOUT_EN
        for (int c = 1; c < MAX_HOLD; c++) begin
            tick();
            chk_out($sformatf("to.hold%0d", c), 5'b10000, 3'd4, 1'b1, 1'b0);
        end
        tick();
        chk_out("to.forced", 5'b00000, 3'd4, 1'b0, 1'b1);
        tick();
        chk_out("to.regrant", 5'b10000, 3'd4, 1'b1, 1'b0);
        for (int c = 1; c < MAX_HOLD; c++) begin
            tick();
        end
        chk_out("to.hold15", 5'b10000, 3'd4, 1'b1, 1'b0);
        bus.done_in = 1'b1;
        tick();
        bus.done_in = 1'b0;
        chk_out("to.donewins", 5'b00000, 3'd4, 1'b0, 1'b0);
`else
        for (int c = 1; c < 3 * MAX_HOLD; c++) begin
            tick();
        end
        chk_out("hold.long", 5'b10000, 3'd4, 1'b1, 1'b0);
        bus.done_in = 1'b1;
        tick();
        bus.done_in = 1'b0;
        chk_out("hold.done", 5'b00000, 3'd4, 1'b0, 1'b0);
`endif
        bus.req = 5'b00000;
        tick();

        // Asynchronous reset mid-grant clears outputs without a clock edge.
        bus.req = 5'b01000;
        tick();
        chk_out("rst.own3", 5'b01000, 3'd3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rst.async", 5'b00000, 3'd0, 1'b0, 1'b0);
        tick();
        bus.req = 5'b11000;
        rst     = 1'b0;
        tick();
        chk_out("rst.regrant", 5'b01000, 3'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule : tb_rr_child_scheduler
